// File: rtl/uart_rx_sipo_if.sv
// Serial-receiver bus: oversampling tick and serial line in, completed frame out.
`timescale 1ns/1ps
interface uart_rx_sipo_if;
  logic        baud_tick;
  logic        rx_in;
  logic [10:0] data_parll;
  logic        recieved_flag;
  logic        busy;

  // Driver side: supplies tick and line, observes the received frame
  modport master (
    output baud_tick, rx_in,
    input  data_parll, recieved_flag, busy
  );

  // Receiver side
  modport slave (
    input  baud_tick, rx_in,
    output data_parll, recieved_flag, busy
  );
endinterface

// File: rtl/uart_rx_sipo.sv
// Oversampling UART receiver delivering the whole 11-bit frame (start, data,
// parity, stop) in parallel. Start bit is validated at mid-bit; parity and
// stop are passed through unchecked for the downstream stage to inspect.
`timescale 1ns/1ps
module uart_rx_sipo #(
  parameter int OVERSAMPLE = 16
) (
  input logic           clk,
  input logic           rst,
  uart_rx_sipo_if.slave bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_CNT = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_CNT = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE = TW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA} state_t;

  state_t          state;
  logic [TW-1:0]   tick_cnt;
  logic [3:0]      bit_cnt;
  logic [10:0]     shift_reg;
  logic [10:0]     data_reg;
  logic            flag_reg;
  logic            busy_reg;
  logic            sync1;
  logic            rx_s;

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= bus.rx_in;
      rx_s  <= sync1;
    end
  end

  // Receive FSM: everything advances only on baud ticks, except the flag pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      flag_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      flag_reg <= 1'b0;
      if (bus.baud_tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              tick_cnt <= '0;
              state    <= START;
              busy_reg <= 1'b1;
            end
          end
          START: begin
            if (tick_cnt == HALF_CNT) begin
              if (!rx_s) begin
                shift_reg <= {rx_s, shift_reg[10:1]};
                tick_cnt  <= '0;
                bit_cnt   <= 4'd1;
                state     <= DATA;
              end else begin
                state    <= IDLE;
                busy_reg <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_ONE;
            end
          end
          DATA: begin
            if (tick_cnt == LAST_CNT) begin
              shift_reg <= {rx_s, shift_reg[10:1]};
              tick_cnt  <= '0;
              bit_cnt   <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd10) begin
                data_reg <= {rx_s, shift_reg[10:1]};
                flag_reg <= 1'b1;
                state    <= IDLE;
                busy_reg <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_ONE;
            end
          end
          default: begin
            state    <= IDLE;
            busy_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data_parll    = data_reg;
  assign bus.recieved_flag = flag_reg;
  assign bus.busy          = busy_reg;

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed self-checking bench for uart_rx_sipo: a table of single frames
// plus hand-written glitch, mid-frame reset and back-to-back sequences.
`timescale 1ns/1ps
module tb_uart_rx_sipo;

  typedef struct {
    logic [7:0]  data;
    logic        parity;
    logic        stop;
    logic [10:0] expected;
  } vec_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   viol_flag;
  int   viol_data;
  logic [10:0] got[$];
  logic [10:0] saved;
  logic [10:0] frame;
  vec_t vecs[6];

  uart_rx_sipo_if ifc();

  uart_rx_sipo #(.OVERSAMPLE(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud tick: one cycle in every four, changed on the falling edge
  initial begin
    ifc.baud_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      ifc.baud_tick = 1'b1;
      @(negedge clk);
      ifc.baud_tick = 1'b0;
    end
  end

  // Monitor: capture every flagged frame, catch long flags and silent data changes
  initial begin
    logic        prev_flag;
    logic [10:0] prev_data;
    prev_flag = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (ifc.recieved_flag === 1'b1) begin
        got.push_back(ifc.data_parll);
        if (prev_flag) viol_flag++;
      end
      if (rst !== 1'b1 && ifc.recieved_flag !== 1'b1 && ifc.data_parll !== prev_data)
        viol_data++;
      prev_flag = ifc.recieved_flag;
      prev_data = ifc.data_parll;
    end
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (ifc.baud_tick !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ifc.rx_in = b;
    wait_ticks(16);
  endtask

  task automatic apply_stimulus(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(f[i]);
  endtask

  task automatic line_idle(input int ticks);
    @(negedge clk);
    ifc.rx_in = 1'b1;
    wait_ticks(ticks);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ifc.rx_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    viol_flag = 0;
    viol_data = 0;
    rst = 1'b1;
    ifc.rx_in = 1'b1;

    vecs[0] = '{data: 8'hA5, parity: 1'b1, stop: 1'b1, expected: 11'h74A};
    vecs[1] = '{data: 8'h3C, parity: 1'b0, stop: 1'b1, expected: 11'h478};
    vecs[2] = '{data: 8'hFF, parity: 1'b0, stop: 1'b0, expected: 11'h1FE};
    vecs[3] = '{data: 8'h00, parity: 1'b0, stop: 1'b1, expected: 11'h400};
    vecs[4] = '{data: 8'h81, parity: 1'b0, stop: 1'b1, expected: 11'h502};
    vecs[5] = '{data: 8'h7E, parity: 1'b1, stop: 1'b1, expected: 11'h6FC};

    // Reset then idle line
    do_reset();
    line_idle(40);
    check_output("reset_data", 32'(ifc.data_parll), 32'h000);
    check_output("reset_flag", 32'(ifc.recieved_flag), 32'h0);
    check_output("reset_busy", 32'(ifc.busy), 32'h0);
    check_output("reset_no_frames", 32'(got.size()), 32'd0);

    // Single frames from the table
    foreach (vecs[k]) begin
      got.delete();
      frame = {vecs[k].stop, vecs[k].parity, vecs[k].data, 1'b0};
      apply_stimulus(frame, 11);
      line_idle(24);
      check_output($sformatf("vec%0d_flags", k), 32'(got.size()), 32'd1);
      if (got.size() > 0)
        check_output($sformatf("vec%0d_flagged_data", k), 32'(got[0]), 32'(vecs[k].expected));
      check_output($sformatf("vec%0d_data", k), 32'(ifc.data_parll), 32'(vecs[k].expected));
      check_output($sformatf("vec%0d_busy", k), 32'(ifc.busy), 32'h0);
    end

    // Glitch: four low ticks, start rejected on the 8th START tick
    got.delete();
    saved = ifc.data_parll;
    @(negedge clk);
    ifc.rx_in = 1'b0;
    wait_ticks(4);
    @(negedge clk);
    ifc.rx_in = 1'b1;
    check_output("glitch_busy_early", 32'(ifc.busy), 32'h1);
    wait_ticks(4);
    @(negedge clk);
    check_output("glitch_busy_before_mid", 32'(ifc.busy), 32'h1);
    wait_ticks(1);
    @(negedge clk);
    check_output("glitch_busy_dropped", 32'(ifc.busy), 32'h0);
    line_idle(40);
    check_output("glitch_no_flag", 32'(got.size()), 32'd0);
    check_output("glitch_data_kept", 32'(ifc.data_parll), 32'(saved));

    // Reset after start plus five data bits, then a full 0x3C frame
    got.delete();
    frame = {1'b1, 1'b0, 8'h3C, 1'b0};
    apply_stimulus(frame, 6);
    check_output("abort_busy_before_reset", 32'(ifc.busy), 32'h1);
    do_reset();
    line_idle(200);
    check_output("abort_no_flag", 32'(got.size()), 32'd0);
    check_output("abort_data_cleared", 32'(ifc.data_parll), 32'h000);
    check_output("abort_busy", 32'(ifc.busy), 32'h0);
    apply_stimulus(frame, 11);
    line_idle(24);
    check_output("after_abort_flags", 32'(got.size()), 32'd1);
    check_output("after_abort_data", 32'(ifc.data_parll), 32'h478);

    // Back-to-back frames with no idle time between them
    got.delete();
    frame = {1'b1, 1'b0, 8'h55, 1'b0};
    apply_stimulus(frame, 11);
    frame = {1'b1, 1'b0, 8'h0F, 1'b0};
    apply_stimulus(frame, 11);
    line_idle(24);
    check_output("b2b_flags", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      check_output("b2b_first", 32'(got[0]), 32'h4AA);
      check_output("b2b_second", 32'(got[1]), 32'h41E);
    end
    check_output("b2b_data", 32'(ifc.data_parll), 32'h41E);

    // Global properties seen by the monitor over the whole run
    check_output("flag_single_cycle", 32'(viol_flag), 32'd0);
    check_output("data_only_on_flag", 32'(viol_data), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_sipo.md
UART_RX_SIPO -- requirements
Module: uart_rx_sipo

Interface
REQ-001 SHALL provide parameter OVERSAMPLE, default 16: baud_tick pulses per serial bit period (even, >= 4).
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port baud_tick  input  1  single-cycle enable at OVERSAMPLE x baud rate.
REQ-005 SHALL provide port rx_in  input  1  asynchronous serial line, idle high.
REQ-006 SHALL provide port data_parll  output  11  last complete frame: [0] start, [8:1] data LSB-first, [9] parity, [10] stop.
REQ-007 SHALL provide port recieved_flag  output  1  one-cycle pulse marking a new data_parll value.
REQ-008 SHALL provide port busy  output  1  high while a frame is in progress (state != IDLE).

Function
REQ-009 SHALL pass rx_in through a two-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-010 SHALL implement states IDLE, START and DATA; busy = 1 in START and DATA.
REQ-011 SHALL hold all counters and state in any cycle with baud_tick = 0.
REQ-012 IDLE: on a baud_tick with rx_s = 0, SHALL clear tick_cnt and enter START.
REQ-013 START: SHALL increment tick_cnt on each baud_tick.
REQ-014 START: on the tick where tick_cnt = OVERSAMPLE/2-1, if rx_s = 0 SHALL shift in bit 0, clear tick_cnt, set bit_cnt = 1 and enter DATA.
REQ-015 START: at that tick, if rx_s = 1 (false start/glitch), SHALL return to IDLE with no flag.
REQ-016 DATA: SHALL increment tick_cnt on each baud_tick.
REQ-017 DATA: on the tick where tick_cnt = OVERSAMPLE-1, SHALL sample rx_s, shift it into the MSB of an internal 11-bit shift register (right shift), clear tick_cnt and increment bit_cnt.
REQ-018 On the sample making bit_cnt = 11, SHALL load data_parll with the completed frame, set recieved_flag = 1 on the next edge and return to IDLE.
REQ-019 recieved_flag SHALL be high for exactly one clk cycle per frame, coincident with the first cycle data_parll shows the new frame.
REQ-020 data_parll SHALL change only on frame completion or reset; partial frames are never visible.
REQ-021 Start-bit validity SHALL be checked only at mid-bit; parity and stop are NOT checked (the downstream stage separates them), so a 0 stop bit is still delivered.
REQ-022 After completion the block SHALL be in IDLE at mid-stop-bit, so an immediately following start edge (zero idle) is detected.
REQ-023 If the line stays low after a 0 stop bit, SHALL begin a new frame from IDLE normally (no special break handling).
REQ-024 tick_cnt width SHALL be clog2(OVERSAMPLE); bit_cnt width SHALL be 4 bits; no counter SHALL wrap in normal operation.

Reset
REQ-025 With rst = 1 at a clk edge, SHALL enter IDLE and clear tick_cnt, bit_cnt, shift register, data_parll = 11'h000, recieved_flag = 0 and busy = 0.
REQ-026 Reset SHALL set both synchronizer flops to 1 (idle line).
REQ-027 Reset SHALL take priority over baud_tick and rx_in in the same cycle.
REQ-028 Reset mid-frame SHALL abort the frame with no flag and no data_parll update.

Verification
REQ-029 Reset: rst = 1 for 2 cycles, then idle line -> data_parll = 11'h000, recieved_flag = 0 and busy = 0 indefinitely.
REQ-030 Frame: data 0xA5, parity 1, stop 1 at OVERSAMPLE = 16 -> data_parll = 11'h74A and recieved_flag high exactly 1 cycle.
REQ-031 Glitch: rx_in low for 4 ticks then high -> busy drops at tick 8, no flag and data_parll unchanged.
REQ-032 Reset after 5 data bits, then full frame 0x3C (parity 0, stop 1) -> no flag for the aborted frame; then data_parll = 11'h478 with one flag.
REQ-033 Back-to-back frames 0x55 then 0x0F with no idle between -> two flags, each with the correct data_parll.
REQ-034 Bad stop: data 0xFF, parity 0, stop 0, line then high -> data_parll = 11'h1FE with flag asserted.
